// File: rtl/rr_encoder_arbiter.sv
// rtl/rr_encoder_arbiter.sv - 8-way round-robin arbiter with hold timeout and encoded grant index
// Registered one-hot grant; grant_idx is the 8-to-3 encoding of that grant.
module rr_encoder_arbiter #(
   parameter int MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       release_grant,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

   state_t     state, state_n;
   logic [2:0] ptr, ptr_n;
   logic [7:0] hold_cnt, hold_n;
   logic [7:0] grant_n;
   logic [2:0] pick, cand;
   logic       pick_found;
   logic       exit_busy;

   // The grant register is the owner record; the index is derived from it.
   assign grant_idx   = {grant[4] | grant[5] | grant[6] | grant[7],
                         grant[2] | grant[3] | grant[6] | grant[7],
                         grant[1] | grant[3] | grant[5] | grant[7]};
   assign grant_valid = |grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         hold_cnt <= 8'd0;
         grant    <= 8'h00;
      end else begin
         state    <= state_n;
         ptr      <= ptr_n;
         hold_cnt <= hold_n;
         grant    <= grant_n;
      end
   end

   always_comb begin
      state_n    = state;
      ptr_n      = ptr;
      hold_n     = hold_cnt;
      grant_n    = grant;
      pick       = 3'd0;
      pick_found = 1'b0;
      cand       = 3'd0;
      exit_busy  = 1'b0;

      // Scan downward so the candidate nearest ptr is the last one written.
      for (int k = 7; k >= 0; k--) begin
         cand = ptr + 3'(k);
         if (req[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end

      exit_busy = release_grant || !req[grant_idx] ||
                  ((MAX_HOLD != 0) && (hold_cnt == HOLD_LIM));

      case (state)
         IDLE: begin
            if (pick_found) begin
               grant_n = 8'b1 << pick;
               hold_n  = 8'd1;
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (exit_busy) begin
               grant_n = 8'h00;
               hold_n  = 8'd0;
               ptr_n   = grant_idx + 3'd1;
               state_n = IDLE;
            end else if (hold_cnt != 8'hFF) begin
               hold_n = hold_cnt + 8'd1;
            end
         end
         default: begin
            grant_n = 8'h00;
            hold_n  = 8'd0;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// tb/tb_rr_encoder_arbiter.sv - directed self-checking bench for rr_encoder_arbiter
// Inputs change and outputs are checked on the falling edge.
module tb_rr_encoder_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       release_grant;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;

   int checks = 0;
   int errors = 0;

   rr_encoder_arbiter #(.MAX_HOLD(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .release_grant(release_grant),
      .grant        (grant),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [7:0] g_exp,
                      input logic [2:0] i_exp, input logic v_exp);
      checks++;
      assert (grant === g_exp) else begin
         errors++;
         $error("FAIL %s grant got %h want %h", tag, grant, g_exp);
      end
      checks++;
      assert (grant_idx === i_exp) else begin
         errors++;
         $error("FAIL %s grant_idx got %0d want %0d", tag, grant_idx, i_exp);
      end
      checks++;
      assert (grant_valid === v_exp) else begin
         errors++;
         $error("FAIL %s grant_valid got %b want %b", tag, grant_valid, v_exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 8'h00;
      release_grant = 1'b0;
      tick();
      tick();
      chk("reset", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      tick();
      chk("idle_noreq", 8'h00, 3'd0, 1'b0);

      // sole requester 0, release three cycles after grant
      req = 8'h01;
      tick();
      chk("r0_grant", 8'h01, 3'd0, 1'b1);
      tick();
      tick();
      chk("r0_hold", 8'h01, 3'd0, 1'b1);
      release_grant = 1'b1;
      tick();
      chk("r0_release", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;
      tick();
      chk("r0_regrant", 8'h01, 3'd0, 1'b1);
      release_grant = 1'b1;
      tick();
      chk("r0_release2", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;

      // all requesting from ptr=0: indices 0..7 then 0, dead cycle between
      rst = 1'b1;
      req = 8'h00;
      tick();
      rst = 1'b0;
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_grant", 8'h01 << (i % 8), 3'(i % 8), 1'b1);
         release_grant = 1'b1;
         tick();
         chk("rr_gap", 8'h00, 3'd0, 1'b0);
         release_grant = 1'b0;
      end

      // ptr=1 with req 0x81: 7 first, then wrap to 0
      req = 8'h81;
      tick();
      chk("wrap_r7", 8'h80, 3'd7, 1'b1);
      release_grant = 1'b1;
      tick();
      chk("wrap_gap", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;
      tick();
      chk("wrap_r0", 8'h01, 3'd0, 1'b1);
      release_grant = 1'b1;
      tick();
      chk("wrap_gap2", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;

      // timeout: ptr=1, req 0x24 held without release
      req = 8'h24;
      tick();
      chk("to_r2_first", 8'h04, 3'd2, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_r2_hold", 8'h04, 3'd2, 1'b1);
      end
      tick();
      chk("to_r2_dead", 8'h00, 3'd0, 1'b0);
      tick();
      chk("to_r5_first", 8'h20, 3'd5, 1'b1);
      for (int i = 0; i < 15; i++) begin
         tick();
         chk("to_r5_hold", 8'h20, 3'd5, 1'b1);
      end
      req = 8'h00;
      tick();
      chk("to_r5_dead", 8'h00, 3'd0, 1'b0);

      // owner drops request mid-grant; ptr=6 here
      req = 8'h08;
      tick();
      chk("drop_r3", 8'h08, 3'd3, 1'b1);
      tick();
      chk("drop_r3_hold", 8'h08, 3'd3, 1'b1);
      req = 8'h00;
      tick();
      chk("drop_clear", 8'h00, 3'd0, 1'b0);
      req = 8'h18;
      tick();
      chk("drop_ptr_adv", 8'h10, 3'd4, 1'b1);
      // drop and release together: one exit, ptr becomes 5
      req = 8'h08;
      release_grant = 1'b1;
      tick();
      chk("dual_exit", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;
      req = 8'h28;
      tick();
      chk("dual_ptr5", 8'h20, 3'd5, 1'b1);
      release_grant = 1'b1;
      tick();
      chk("dual_rel", 8'h00, 3'd0, 1'b0);
      req = 8'h00;
      tick();
      chk("idle_release", 8'h00, 3'd0, 1'b0);
      release_grant = 1'b0;

      // reset mid-grant on requester 6
      req = 8'h40;
      tick();
      chk("rst_r6", 8'h40, 3'd6, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_busy", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      req = 8'hC0;
      tick();
      chk("rst_regrant", 8'h40, 3'd6, 1'b1);
      release_grant = 1'b1;
      tick();
      release_grant = 1'b0;
      tick();
      chk("rst_next_r7", 8'h80, 3'd7, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
